// File: rtl/decode_stage.sv
// Decode stage: instruction decode, 16-entry register file with R15 = PC+8,
// immediate extension and the Decode/Execute pipeline register.
module decode_stage #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] InstrD,
   input  logic [N-1:0] PCPlus8D,
   input  logic [N-1:0] ResultW,
   input  logic [3:0]   WA3W,
   input  logic         RegWriteW,
   input  logic         StallE,
   input  logic         FlushE,
   output logic [3:0]   RA1D,
   output logic [3:0]   RA2D,
   output logic [N-1:0] RD1E,
   output logic [N-1:0] RD2E,
   output logic [N-1:0] ExtImmE,
   output logic [3:0]   WA3E,
   output logic [3:0]   RA1E,
   output logic [3:0]   RA2E,
   output logic         RegWriteE,
   output logic         MemWriteE,
   output logic         MemtoRegE,
   output logic         ALUSrcE,
   output logic         BranchE,
   output logic         PCSrcE,
   output logic [2:0]   ALUControlE
);

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_ORR  = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_ADDI = 4'b0101;
   localparam logic [3:0] OP_LDR  = 4'b0110;
   localparam logic [3:0] OP_STR  = 4'b0111;
   localparam logic [3:0] OP_B    = 4'b1000;
   localparam logic [3:0] OP_MOV  = 4'b1001;
   localparam logic [3:0] PC_REG  = 4'd15;

   logic [3:0]   op_s, rd_s, rs1_s, rs2_s;
   logic [15:0]  imm16_s;
   logic [N-1:0] sext_s, zext_s, bext_s;

   logic         reg_write_s, mem_write_s, memto_reg_s, alu_src_s, branch_s, pc_src_s;
   logic [2:0]   alu_control_s;
   logic [N-1:0] ext_imm_s;
   logic [N-1:0] rd1_s, rd2_s;
   logic         wr_en_s;

   logic [N-1:0] rf_r [16];

   logic [N-1:0] rd1_r, rd2_r, ext_imm_r;
   logic [3:0]   wa3_r, ra1_r, ra2_r;
   logic         reg_write_r, mem_write_r, memto_reg_r, alu_src_r, branch_r, pc_src_r;
   logic [2:0]   alu_control_r;

   assign op_s    = InstrD[31:28];
   assign rd_s    = InstrD[27:24];
   assign rs1_s   = InstrD[23:20];
   assign rs2_s   = InstrD[19:16];
   assign imm16_s = InstrD[15:0];

   assign sext_s = {{(N-16){imm16_s[15]}}, imm16_s};
   assign zext_s = {{(N-16){1'b0}}, imm16_s};
   assign bext_s = {{(N-18){1'b0}}, imm16_s, 2'b00};

   assign RA1D = rs1_s;
   assign RA2D = (op_s == OP_STR) ? rd_s : rs2_s;

   // Opcode decode into execute controls and extended immediate
   always_comb begin
      reg_write_s   = 1'b0;
      mem_write_s   = 1'b0;
      memto_reg_s   = 1'b0;
      alu_src_s     = 1'b0;
      branch_s      = 1'b0;
      alu_control_s = 3'b000;
      ext_imm_s     = '0;
      case (op_s)
         OP_ADD: reg_write_s = 1'b1;
         OP_SUB: begin reg_write_s = 1'b1; alu_control_s = 3'b001; end
         OP_AND: begin reg_write_s = 1'b1; alu_control_s = 3'b010; end
         OP_ORR: begin reg_write_s = 1'b1; alu_control_s = 3'b011; end
         OP_XOR: begin reg_write_s = 1'b1; alu_control_s = 3'b100; end
         OP_ADDI: begin
            reg_write_s = 1'b1;
            alu_src_s   = 1'b1;
            ext_imm_s   = sext_s;
         end
         OP_LDR: begin
            reg_write_s = 1'b1;
            memto_reg_s = 1'b1;
            alu_src_s   = 1'b1;
            ext_imm_s   = sext_s;
         end
         OP_STR: begin
            mem_write_s = 1'b1;
            alu_src_s   = 1'b1;
            ext_imm_s   = sext_s;
         end
         OP_B: begin
            alu_src_s     = 1'b1;
            branch_s      = 1'b1;
            alu_control_s = 3'b101;
            ext_imm_s     = bext_s;
         end
         OP_MOV: begin
            reg_write_s   = 1'b1;
            alu_src_s     = 1'b1;
            alu_control_s = 3'b101;
            ext_imm_s     = zext_s;
         end
         default: begin
            reg_write_s   = 1'b0;
            alu_control_s = 3'b000;
         end
      endcase
   end

   assign pc_src_s = reg_write_s & (rd_s == PC_REG);
   assign wr_en_s  = RegWriteW & (WA3W != PC_REG);

   // Register reads: R15 yields PC+8, a same-cycle writeback is bypassed
   always_comb begin
      rd1_s = '0;
      rd2_s = '0;
      if (RA1D == PC_REG) begin
         rd1_s = PCPlus8D;
      end else if (wr_en_s && (RA1D == WA3W)) begin
         rd1_s = ResultW;
      end else begin
         rd1_s = rf_r[RA1D];
      end
      if (RA2D == PC_REG) begin
         rd2_s = PCPlus8D;
      end else if (wr_en_s && (RA2D == WA3W)) begin
         rd2_s = ResultW;
      end else begin
         rd2_s = rf_r[RA2D];
      end
   end

   // Register file storage; entry 15 is never written since R15 is the PC
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) rf_r[i] <= '0;
      end else if (wr_en_s) begin
         rf_r[WA3W] <= ResultW;
      end
   end

   // Decode/Execute register: reset and flush insert a bubble, stall holds
   always_ff @(posedge clk) begin
      if (rst || FlushE) begin
         rd1_r         <= '0;
         rd2_r         <= '0;
         ext_imm_r     <= '0;
         wa3_r         <= 4'd0;
         ra1_r         <= 4'd0;
         ra2_r         <= 4'd0;
         reg_write_r   <= 1'b0;
         mem_write_r   <= 1'b0;
         memto_reg_r   <= 1'b0;
         alu_src_r     <= 1'b0;
         branch_r      <= 1'b0;
         pc_src_r      <= 1'b0;
         alu_control_r <= 3'b000;
      end else if (!StallE) begin
         rd1_r         <= rd1_s;
         rd2_r         <= rd2_s;
         ext_imm_r     <= ext_imm_s;
         wa3_r         <= rd_s;
         ra1_r         <= RA1D;
         ra2_r         <= RA2D;
         reg_write_r   <= reg_write_s;
         mem_write_r   <= mem_write_s;
         memto_reg_r   <= memto_reg_s;
         alu_src_r     <= alu_src_s;
         branch_r      <= branch_s;
         pc_src_r      <= pc_src_s;
         alu_control_r <= alu_control_s;
      end
   end

   assign RD1E        = rd1_r;
   assign RD2E        = rd2_r;
   assign ExtImmE     = ext_imm_r;
   assign WA3E        = wa3_r;
   assign RA1E        = ra1_r;
   assign RA2E        = ra2_r;
   assign RegWriteE   = reg_write_r;
   assign MemWriteE   = mem_write_r;
   assign MemtoRegE   = memto_reg_r;
   assign ALUSrcE     = alu_src_r;
   assign BranchE     = branch_r;
   assign PCSrcE      = pc_src_r;
   assign ALUControlE = alu_control_r;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: expected E-stage bundles are queued
// when stimulus is applied and popped/compared one cycle later.
module tb_decode_stage;

   typedef struct packed {
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] ext;
      logic [3:0]  wa3;
      logic [3:0]  ra1;
      logic [3:0]  ra2;
      logic        rw;
      logic        mw;
      logic        m2r;
      logic        asrc;
      logic        br;
      logic        pcs;
      logic [2:0]  aluc;
   } e_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] InstrD, PCPlus8D, ResultW;
   logic [3:0]  WA3W;
   logic        RegWriteW, StallE, FlushE;
   logic [3:0]  RA1D, RA2D;
   logic [31:0] RD1E, RD2E, ExtImmE;
   logic [3:0]  WA3E, RA1E, RA2E;
   logic        RegWriteE, MemWriteE, MemtoRegE, ALUSrcE, BranchE, PCSrcE;
   logic [2:0]  ALUControlE;

   int   n_cmp = 0;
   int   n_err = 0;
   e_t   sb[$];
   e_t   exp_v;
   e_t   zero_v;
   logic [31:0] model [16];

   decode_stage #(.N(32)) dut (
      .clk(clk), .rst(rst), .InstrD(InstrD), .PCPlus8D(PCPlus8D),
      .ResultW(ResultW), .WA3W(WA3W), .RegWriteW(RegWriteW),
      .StallE(StallE), .FlushE(FlushE), .RA1D(RA1D), .RA2D(RA2D),
      .RD1E(RD1E), .RD2E(RD2E), .ExtImmE(ExtImmE), .WA3E(WA3E),
      .RA1E(RA1E), .RA2E(RA2E), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
      .MemtoRegE(MemtoRegE), .ALUSrcE(ALUSrcE), .BranchE(BranchE),
      .PCSrcE(PCSrcE), .ALUControlE(ALUControlE)
   );

   always #5 clk = ~clk;

   function automatic e_t obs();
      return {RD1E, RD2E, ExtImmE, WA3E, RA1E, RA2E, RegWriteE, MemWriteE,
              MemtoRegE, ALUSrcE, BranchE, PCSrcE, ALUControlE};
   endfunction

   function automatic e_t mk(logic [31:0] rd1, logic [31:0] rd2, logic [31:0] ext,
                             logic [3:0] wa3, logic [3:0] ra1, logic [3:0] ra2,
                             logic rw, logic mw, logic m2r, logic asrc, logic br,
                             logic pcs, logic [2:0] aluc);
      return {rd1, rd2, ext, wa3, ra1, ra2, rw, mw, m2r, asrc, br, pcs, aluc};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_wb(logic rw, logic [3:0] wa, logic [31:0] res);
      RegWriteW = rw;
      WA3W      = wa;
      ResultW   = res;
   endtask

   task automatic test_reset();
      rst = 1'b1; InstrD = 32'h0130_0000; set_wb(1'b0, 4'd0, 32'd0);
      sb.push_back(zero_v); cyc();
      exp_v = sb.pop_front(); n_cmp++;
      if (obs() !== exp_v) begin n_err++; $display("FAIL reset_bubble: got %h want %h", obs(), exp_v); end
      rst = 1'b0; InstrD = 32'hF000_0000; set_wb(1'b1, 4'd3, 32'h55);
      sb.push_back(zero_v); cyc();
      exp_v = sb.pop_front(); n_cmp++;
      if (obs() !== exp_v) begin n_err++; $display("FAIL nop_after_reset: got %h want %h", obs(), exp_v); end
      rst = 1'b1; InstrD = 32'h0130_0000; set_wb(1'b1, 4'd3, 32'h77);
      sb.push_back(zero_v); cyc();
      exp_v = sb.pop_front(); n_cmp++;
      if (obs() !== exp_v) begin n_err++; $display("FAIL reset_midop: got %h want %h", obs(), exp_v); end
      rst = 1'b0; set_wb(1'b0, 4'd0, 32'd0);
      for (int i = 0; i < 16; i++) model[i] = 32'd0;
      sb.push_back(mk(32'd0, 32'd0, 32'd0, 4'd1, 4'd3, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000));
      cyc();
      exp_v = sb.pop_front(); n_cmp++;
      if (obs() !== exp_v) begin n_err++; $display("FAIL reset_r3_zero: got %h want %h", obs(), exp_v); end
   endtask

   task automatic test_writeback_read();
      InstrD = 32'hF000_0000; set_wb(1'b1, 4'd3, 32'hAA); model[3] = 32'hAA;
      sb.push_back(zero_v); cyc();
      exp_v = sb.pop_front(); n_cmp++;
      if (obs() !== exp_v) begin n_err++; $display("FAIL wb_nop: got %h want %h", obs(), exp_v); end
      InstrD = 32'h0130_0000; set_wb(1'b0, 4'd0, 32'd0);
      sb.push_back(mk(32'hAA, 32'd0, 32'd0, 4'd1, 4'd3, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000));
      cyc();
      exp_v = sb.pop_front(); n_cmp++;
      if (obs() !== exp_v) begin n_err++; $display("FAIL wb_read_r3: got %h want %h", obs(), exp_v); end
   endtask

   task automatic test_bypass_r15();
      InstrD = 32'h005F_0000; PCPlus8D = 32'h40; set_wb(1'b1, 4'd5, 32'h1234); model[5] = 32'h1234;
      sb.push_back(mk(32'h1234, 32'h40, 32'd0, 4'd0, 4'd5, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000));
      cyc();
      exp_v = sb.pop_front(); n_cmp++;
      if (obs() !== exp_v) begin n_err++; $display("FAIL bypass_r5_r15: got %h want %h", obs(), exp_v); end
      InstrD = 32'h00FF_0000; PCPlus8D = 32'h48; set_wb(1'b1, 4'd15, 32'hDEAD);
      sb.push_back(mk(32'h48, 32'h48, 32'd0, 4'd0, 4'd15, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000));
      cyc();
      exp_v = sb.pop_front(); n_cmp++;
      if (obs() !== exp_v) begin n_err++; $display("FAIL r15_write_same_cycle: got %h want %h", obs(), exp_v); end
      InstrD = 32'h00F5_0000; PCPlus8D = 32'h4C; set_wb(1'b0, 4'd0, 32'd0);
      sb.push_back(mk(32'h4C, 32'h1234, 32'd0, 4'd0, 4'd15, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000));
      cyc();
      exp_v = sb.pop_front(); n_cmp++;
      if (obs() !== exp_v) begin n_err++; $display("FAIL r15_after_write: got %h want %h", obs(), exp_v); end
   endtask

   task automatic test_immediate();
      InstrD = 32'h6230_FFFC;
      sb.push_back(mk(32'hAA, 32'd0, 32'hFFFF_FFFC, 4'd2, 4'd3, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000));
      cyc();
      exp_v = sb.pop_front(); n_cmp++;
      if (obs() !== exp_v) begin n_err++; $display("FAIL ldr_sext: got %h want %h", obs(), exp_v); end
      InstrD = 32'h8000_0010;
      sb.push_back(mk(32'd0, 32'd0, 32'h40, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b101));
      cyc();
      exp_v = sb.pop_front(); n_cmp++;
      if (obs() !== exp_v) begin n_err++; $display("FAIL branch_imm: got %h want %h", obs(), exp_v); end
      InstrD = 32'h9400_8000;
      sb.push_back(mk(32'd0, 32'd0, 32'h0000_8000, 4'd4, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b101));
      cyc();
      exp_v = sb.pop_front(); n_cmp++;
      if (obs() !== exp_v) begin n_err++; $display("FAIL mov_zext: got %h want %h", obs(), exp_v); end
      InstrD = 32'h7730_0008;
      #1;
      n_cmp++;
      if (RA2D !== 4'd7) begin n_err++; $display("FAIL str_ra2d: got %h want %h", RA2D, 4'd7); end
      sb.push_back(mk(32'hAA, 32'd0, 32'd8, 4'd7, 4'd3, 4'd7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000));
      cyc();
      exp_v = sb.pop_front(); n_cmp++;
      if (obs() !== exp_v) begin n_err++; $display("FAIL str_ctrl: got %h want %h", obs(), exp_v); end
   endtask

   task automatic test_stall_flush();
      e_t add_v;
      add_v = mk(32'hAA, 32'd0, 32'd0, 4'd1, 4'd3, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
      InstrD = 32'h0130_0000;
      sb.push_back(add_v); cyc();
      exp_v = sb.pop_front(); n_cmp++;
      if (obs() !== exp_v) begin n_err++; $display("FAIL stall_load: got %h want %h", obs(), exp_v); end
      StallE = 1'b1; InstrD = 32'h9400_8000;
      for (int k = 0; k < 2; k++) begin
         sb.push_back(add_v); cyc();
         exp_v = sb.pop_front(); n_cmp++;
         if (obs() !== exp_v) begin n_err++; $display("FAIL stall_hold%0d: got %h want %h", k, obs(), exp_v); end
      end
      FlushE = 1'b1;
      sb.push_back(zero_v); cyc();
      exp_v = sb.pop_front(); n_cmp++;
      if (obs() !== exp_v) begin n_err++; $display("FAIL flush_over_stall: got %h want %h", obs(), exp_v); end
      StallE = 1'b0; FlushE = 1'b0; InstrD = 32'h5F30_0001;
      sb.push_back(mk(32'hAA, 32'd0, 32'd1, 4'd15, 4'd3, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000));
      cyc();
      exp_v = sb.pop_front(); n_cmp++;
      if (obs() !== exp_v) begin n_err++; $display("FAIL addi_pcsrc: got %h want %h", obs(), exp_v); end
   endtask

   task automatic test_undefined();
      InstrD = 32'hF130_1234;
      sb.push_back(mk(32'hAA, 32'd0, 32'd0, 4'd1, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000));
      cyc();
      exp_v = sb.pop_front(); n_cmp++;
      if (obs() !== exp_v) begin n_err++; $display("FAIL undefined_op: got %h want %h", obs(), exp_v); end
   endtask

   task automatic test_back_to_back();
      logic [3:0]  wr, rs;
      logic [31:0] val, e1;
      for (int i = 0; i < 10; i++) begin
         wr  = 4'($urandom_range(1, 14));
         rs  = 4'($urandom_range(0, 14));
         val = $urandom;
         InstrD = {4'b0001, 4'd2, rs, wr, 16'h0000};
         set_wb(1'b1, wr, val);
         e1 = (rs == wr) ? val : model[rs];
         sb.push_back(mk(e1, val, 32'd0, 4'd2, rs, wr, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001));
         model[wr] = val;
         cyc();
         exp_v = sb.pop_front(); n_cmp++;
         if (obs() !== exp_v) begin n_err++; $display("FAIL b2b_%0d: got %h want %h", i, obs(), exp_v); end
      end
      set_wb(1'b0, 4'd0, 32'd0);
   endtask

   initial begin
      zero_v = '0;
      rst = 1'b1; InstrD = 32'd0; PCPlus8D = 32'd0; ResultW = 32'd0;
      WA3W = 4'd0; RegWriteW = 1'b0; StallE = 1'b0; FlushE = 1'b0;
      cyc();
      test_reset();
      test_writeback_read();
      test_bypass_r15();
      test_immediate();
      test_stall_flush();
      test_undefined();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
